// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the accumulator controller and its command FIFO:
//   - 3-bit ALU function codes (ALU_ADD .. ALU_EQ)
//   - FSM state enum for the controller
//   - packed command record {mode, operand, load, wb}
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_LT  = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]        mode;
    logic [DATA_W-1:0] operand;
    logic              load;
    logic              wb;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous show-ahead FIFO holding queued ALU commands.
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  entry width in bits
// Ports:
//   clk        clock, all updates on the rising edge
//   rst_n      synchronous active-low reset; empties the FIFO
//   push       write push_data when not full
//   push_data  entry to write
//   pop        drop the head entry when not empty
//   pop_data   current head entry (valid while !empty)
//   full       no free entry; a push is ignored even if a pop happens too
//   empty      no entry stored
// ---------------------------------------------------------------------------
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count do, so
  // stale entries are unreachable after reset and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_accumulator_ctrl.sv
// ---------------------------------------------------------------------------
// alu_accumulator_ctrl
// Command-driven accumulator sequencer placed in front of the 16-bit
// 8-function combinational ALU. Commands are queued in a FIFO, executed one
// at a time (IDLE -> EXEC -> RESP), and each result is returned through a
// valid/ready handshake. The accumulator drives ALU input A at all times.
//
// Optional feature macro: ALU_ACC_FLAGS_EN adds output_flags {carry, zero}.
//
// Ports:
//   input_clock        clock
//   input_reset_n      synchronous active-low reset
//   input_cmd_valid    command present
//   output_cmd_ready   FIFO not full
//   input_cmd_mode     ALU function for the command
//   input_cmd_operand  B operand, or value to load
//   input_cmd_load     load operand into ACC (ALU result ignored)
//   input_cmd_wb       write ALU result back into ACC
//   output_alu_a       ALU A input (= ACC)
//   output_alu_b       ALU B input (latched operand)
//   output_alu_mode    ALU function select (latched mode)
//   input_alu_result   ALU combinational result
//   output_res_valid   result available
//   input_res_ready    consumer accepts the result
//   output_res_data    captured result (loaded value for load commands)
//   output_acc         current accumulator
//   output_flags       {carry, zero}, only with ALU_ACC_FLAGS_EN
// ---------------------------------------------------------------------------
module alu_accumulator_ctrl
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        input_clock,
  input  logic        input_reset_n,
  input  logic        input_cmd_valid,
  output logic        output_cmd_ready,
  input  logic [2:0]  input_cmd_mode,
  input  logic [15:0] input_cmd_operand,
  input  logic        input_cmd_load,
  input  logic        input_cmd_wb,
  output logic [15:0] output_alu_a,
  output logic [15:0] output_alu_b,
  output logic [2:0]  output_alu_mode,
  input  logic [15:0] input_alu_result,
  output logic        output_res_valid,
  input  logic        input_res_ready,
  output logic [15:0] output_res_data,
  output logic [15:0] output_acc
`ifdef ALU_ACC_FLAGS_EN
  ,
  output logic [1:0]  output_flags
`endif
);

  state_t      state;
  state_t      state_next;
  cmd_t        cmd_q;
  cmd_t        cmd_in;
  cmd_t        fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic [15:0] acc;
  logic [15:0] res_data;
  logic [15:0] res_next;

  assign cmd_in = '{
    mode:    input_cmd_mode,
    operand: input_cmd_operand,
    load:    input_cmd_load,
    wb:      input_cmd_wb
  };

  assign fifo_push = input_cmd_valid;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (input_clock),
    .rst_n     (input_reset_n),
    .push      (fifo_push),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Value captured at the end of EXEC: a load bypasses the ALU entirely.
  assign res_next = cmd_q.load ? cmd_q.operand : input_alu_result;

  // NOTE: next-state is assigned a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (input_res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge input_clock) begin
    if (!input_reset_n) begin
      state    <= IDLE;
      cmd_q    <= '0;
      acc      <= '0;
      res_data <= '0;
    end else begin
      state <= state_next;
      if (fifo_pop) begin
        cmd_q <= fifo_head;
      end
      if (state == EXEC) begin
        res_data <= res_next;
        if (cmd_q.load) begin
          acc <= cmd_q.operand;
        end else if (cmd_q.wb) begin
          acc <= input_alu_result;
        end
      end
    end
  end

`ifdef ALU_ACC_FLAGS_EN
  logic [16:0] add_wide;
  logic        carry_next;
  logic [1:0]  flags_q;

  assign add_wide = {1'b0, acc} + {1'b0, cmd_q.operand};

  // Carry is the add carry-out or the subtract borrow; other modes clear it.
  always_comb begin
    carry_next = 1'b0;
    if (!cmd_q.load) begin
      if (cmd_q.mode == ALU_ADD) begin
        carry_next = add_wide[16];
      end else if (cmd_q.mode == ALU_SUB) begin
        carry_next = (acc < cmd_q.operand);
      end
    end
  end

  always_ff @(posedge input_clock) begin
    if (!input_reset_n) begin
      flags_q <= '0;
    end else if (state == EXEC) begin
      flags_q <= {carry_next, (res_next == 16'h0000)};
    end
  end

  assign output_flags = flags_q;
`endif

  assign output_cmd_ready = !fifo_full;
  assign output_alu_a     = acc;
  assign output_alu_b     = cmd_q.operand;
  assign output_alu_mode  = cmd_q.mode;
  assign output_res_valid = (state == RESP);
  assign output_res_data  = res_data;
  assign output_acc       = acc;

endmodule

// File: tb/tb_alu_accumulator_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_accumulator_ctrl
// Self-checking bench for alu_accumulator_ctrl. A behavioural ALU closes the
// loop from output_alu_* back to input_alu_result. Expected results are
// queued when a command is accepted and compared when the result handshake
// completes. Inputs change 2 ns after the rising edge; outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_accumulator_ctrl;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_mode;
  logic [15:0] cmd_operand;
  logic        cmd_load;
  logic        cmd_wb;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_mode;
  logic [15:0] alu_result;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [15:0] acc;
  logic [1:0]  flags;

  typedef struct {
    logic [15:0] res;
    logic [15:0] acc;
    logic [1:0]  flags;
  } exp_t;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] op;
    logic        ld;
    logic        wb;
    logic [15:0] e_res;
    logic [15:0] e_acc;
    logic [1:0]  e_fl;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[20];
  logic [15:0] model_acc;
  int          n_tests;
  int          n_fail;

  alu_accumulator_ctrl #(.FIFO_DEPTH(4)) dut (
    .input_clock       (clk),
    .input_reset_n     (rst_n),
    .input_cmd_valid   (cmd_valid),
    .output_cmd_ready  (cmd_ready),
    .input_cmd_mode    (cmd_mode),
    .input_cmd_operand (cmd_operand),
    .input_cmd_load    (cmd_load),
    .input_cmd_wb      (cmd_wb),
    .output_alu_a      (alu_a),
    .output_alu_b      (alu_b),
    .output_alu_mode   (alu_mode),
    .input_alu_result  (alu_result),
    .output_res_valid  (res_valid),
    .input_res_ready   (res_ready),
    .output_res_data   (res_data),
    .output_acc        (acc)
`ifdef ALU_ACC_FLAGS_EN
    ,
    .output_flags      (flags)
`endif
  );

`ifndef ALU_ACC_FLAGS_EN
  assign flags = 2'b00;
`endif

  // Behavioural stand-in for the external combinational ALU.
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] m);
    case (m)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return {15'd0, (a == 16'h0000)};
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a ^ b;
      3'b110:  return {15'd0, (a < b)};
      default: return {15'd0, (a == b)};
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_mode);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every completed result handshake is compared in order.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stale_result: got %0h expected no result", res_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_data", 32'(res_data), 32'(e.res));
        check("acc_after", 32'(acc), 32'(e.acc));
`ifdef ALU_ACC_FLAGS_EN
        check("flags", 32'(flags), 32'(e.flags));
`endif
      end
    end
  end

  // Drive one command, wait (bounded) for acceptance, queue its expectation.
  task automatic send(input logic [2:0] m, input logic [15:0] op, input logic ld,
                      input logic wb, input exp_t e);
    int   guard;
    logic accepted;
    guard       = 0;
    accepted    = 1'b0;
    cmd_valid   = 1'b1;
    cmd_mode    = m;
    cmd_operand = op;
    cmd_load    = ld;
    cmd_wb      = wb;
    while (!accepted && guard < 200) begin
      @(negedge clk);
      if (cmd_ready) begin
        accepted = 1'b1;
      end else begin
        tick();
        guard++;
      end
    end
    if (accepted) begin
      sb_q.push_back(e);
      tick();
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_accept_timeout: got ready=0 expected ready=1");
    end
    cmd_valid = 1'b0;
  endtask

  // Send a command whose expectation comes from the reference model.
  task automatic send_model(input logic [2:0] m, input logic [15:0] op,
                            input logic ld, input logic wb);
    exp_t        e;
    logic [16:0] wide;
    logic        c;
    wide  = {1'b0, model_acc} + {1'b0, op};
    e.res = ld ? op : alu_f(model_acc, op, m);
    c     = 1'b0;
    if (!ld && m == ALU_ADD) c = wide[16];
    if (!ld && m == ALU_SUB) c = (model_acc < op);
    if (ld) model_acc = op;
    else if (wb) model_acc = e.res;
    e.acc   = model_acc;
    e.flags = {c, (e.res == 16'h0000)};
    send(m, op, ld, wb, e);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || res_valid) && guard < 300) begin
      tick();
      guard++;
    end
    if (guard >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    repeat (4) tick();
  endtask

  initial begin
    int   lat;
    int   guard;
    exp_t e;

    n_tests     = 0;
    n_fail      = 0;
    model_acc   = 16'h0000;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_mode    = 3'b000;
    cmd_operand = 16'h0000;
    cmd_load    = 1'b0;
    cmd_wb      = 1'b0;
    res_ready   = 1'b1;

    //               mode    operand    ld    wb    res        acc        {c,z}
    vecs[0]  = '{3'b000, 16'h1234, 1'b1, 1'b0, 16'h1234, 16'h1234, 2'b00};
    vecs[1]  = '{3'b000, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 2'b00};
    vecs[2]  = '{3'b000, 16'h0001, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'b11};
    vecs[3]  = '{3'b000, 16'h0005, 1'b1, 1'b0, 16'h0005, 16'h0005, 2'b00};
    vecs[4]  = '{3'b001, 16'h0007, 1'b0, 1'b0, 16'hFFFE, 16'h0005, 2'b10};
    vecs[5]  = '{3'b000, 16'h0003, 1'b1, 1'b0, 16'h0003, 16'h0003, 2'b00};
    vecs[6]  = '{3'b110, 16'h0004, 1'b0, 1'b0, 16'h0001, 16'h0003, 2'b00};
    vecs[7]  = '{3'b111, 16'h0003, 1'b0, 1'b0, 16'h0001, 16'h0003, 2'b00};
    vecs[8]  = '{3'b010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0003, 2'b01};
    vecs[9]  = '{3'b011, 16'hFF0F, 1'b0, 1'b1, 16'h0003, 16'h0003, 2'b00};
    vecs[10] = '{3'b100, 16'h00F0, 1'b0, 1'b1, 16'h00F3, 16'h00F3, 2'b00};
    vecs[11] = '{3'b101, 16'h00FF, 1'b0, 1'b1, 16'h000C, 16'h000C, 2'b00};
    vecs[12] = '{3'b001, 16'h000C, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'b01};
    vecs[13] = '{3'b000, 16'h8000, 1'b0, 1'b1, 16'h8000, 16'h8000, 2'b00};
    vecs[14] = '{3'b000, 16'h8000, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'b11};
    vecs[15] = '{3'b000, 16'hABCD, 1'b1, 1'b1, 16'hABCD, 16'hABCD, 2'b00};
    vecs[16] = '{3'b110, 16'hABCD, 1'b0, 1'b0, 16'h0000, 16'hABCD, 2'b01};
    vecs[17] = '{3'b001, 16'h0001, 1'b0, 1'b1, 16'hABCC, 16'hABCC, 2'b00};
    vecs[18] = '{3'b111, 16'h1234, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'b01};
    vecs[19] = '{3'b010, 16'h5555, 1'b0, 1'b1, 16'h0001, 16'h0001, 2'b00};

    // Reset state.
    repeat (3) tick();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_mode", 32'(alu_mode), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    tick();

    // First command latency: accept cycle, pop cycle, execute cycle, then valid.
    cmd_valid   = 1'b1;
    cmd_mode    = 3'b000;
    cmd_operand = 16'h1234;
    cmd_load    = 1'b1;
    cmd_wb      = 1'b0;
    e           = '{res: 16'h1234, acc: 16'h1234, flags: 2'b00};
    sb_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("first_latency", 32'(lat), 32'd2);
    check("load_acc_out", 32'(acc), 32'h1234);
    model_acc = 16'h1234;
    wait_drain();

    // Table of single commands with hand-computed expectations.
    for (int i = 0; i < 20; i++) begin
      e = '{res: vecs[i].e_res, acc: vecs[i].e_acc, flags: vecs[i].e_fl};
      send(vecs[i].mode, vecs[i].op, vecs[i].ld, vecs[i].wb, e);
      model_acc = vecs[i].e_acc;
    end
    wait_drain();

    // Back-pressure: one command stalled in RESP plus four queued fills the FIFO.
    res_ready = 1'b0;
    send_model(ALU_ADD, 16'h0010, 1'b0, 1'b1);
    send_model(ALU_SUB, 16'h0003, 1'b0, 1'b1);
    send_model(ALU_XOR, 16'h00FF, 1'b0, 1'b0);
    send_model(ALU_AND, 16'h0F0F, 1'b0, 1'b1);
    send_model(ALU_ADD, 16'hFFFF, 1'b0, 1'b1);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_res_valid", 32'(res_valid), 32'd1);
    // A push while full must be dropped.
    cmd_valid   = 1'b1;
    cmd_mode    = ALU_OR;
    cmd_operand = 16'hDEAD;
    cmd_load    = 1'b1;
    cmd_wb      = 1'b0;
    repeat (3) tick();
    cmd_valid = 1'b0;
    check("still_full", 32'(cmd_ready), 32'd0);
    res_ready = 1'b1;
    wait_drain();
    check("chain_final_acc", 32'(acc), 32'(model_acc));

    // Reset while a result is pending and two commands are queued.
    res_ready = 1'b0;
    send_model(ALU_ADD, 16'h0001, 1'b0, 1'b1);
    send_model(ALU_ADD, 16'h0002, 1'b0, 1'b1);
    send_model(ALU_ADD, 16'h0003, 1'b0, 1'b1);
    guard = 0;
    while (!res_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("pre_reset_valid", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_acc", 32'(acc), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    sb_q.delete();
    model_acc = 16'h0000;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    repeat (15) tick();
    check("post_rst_idle_valid", 32'(res_valid), 32'd0);

    // Normal operation resumes from a cleared accumulator.
    send_model(ALU_ADD, 16'h0005, 1'b0, 1'b1);
    wait_drain();
    check("post_rst_acc", 32'(acc), 32'h0005);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
